// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
//
// Consumes a byte stream (valid/ready) of the form
//   CNT_LO, CNT_HI, N x {b0,b1,b2,b3}, CSUM
// and writes each assembled little-endian word into instruction RAM starting
// at BASE_ADDR. The CPU is held in reset until the whole program has been
// written and the 8-bit additive checksum matches.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     in_data holds a byte
//   in_data      stream byte
//   in_ready     loader accepts a byte this cycle
//   we           instruction RAM write enable (one-cycle pulse)
//   waddr        instruction RAM byte address (word aligned)
//   wdata        instruction word
//   cpu_rst      CPU reset, high until a successful load
//   done         load complete and checksum matched
//   error        load aborted (bad header or bad checksum)
//   words_loaded number of words written so far
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int unsigned MAX_WORDS = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    ST_HDR0 = 3'd0,
    ST_HDR1 = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam logic [16:0] MAX_WORDS_W = MAX_WORDS[16:0];

  // Running 8-bit checksum accumulation (sum mod 256).
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic        in_ready_r;
  logic        cpu_rst_r;
  logic        done_r;
  logic        error_r;
  logic        we_r;
  logic [31:0] waddr_r;
  logic [31:0] wdata_r;
  logic [15:0] cnt_r;
  logic [7:0]  csum_r;
  logic [1:0]  byte_idx_r;
  logic [15:0] word_idx_r;
  logic [23:0] buf_r;
  logic        accept_s;
  logic [15:0] count_s;

  assign accept_s = in_valid && in_ready_r;
  // Full word count as it will be once CNT_HI is latched.
  assign count_s  = {in_data, cnt_r[7:0]};

  // Next-state logic for the load sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_HDR0: begin
        if (accept_s) begin
          state_s = ST_HDR1;
        end else begin
          state_s = state_r;
        end
      end
      ST_HDR1: begin
        if (accept_s) begin
          if ((count_s == 16'd0) || ({1'b0, count_s} > MAX_WORDS_W)) begin
            state_s = ST_ERR;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_DATA: begin
        if (accept_s && (byte_idx_r == 2'd3) && (word_idx_r == (cnt_r - 16'd1))) begin
          state_s = ST_CSUM;
        end else begin
          state_s = state_r;
        end
      end
      ST_CSUM: begin
        if (accept_s) begin
          if (in_data == csum_r) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ERR;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_DONE: state_s = ST_DONE;
      ST_ERR:  state_s = ST_ERR;
      // Unused encodings fall into the safe aborted state (CPU stays in reset).
      default: state_s = ST_ERR;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_HDR0;
    end else begin
      state_r <= state_s;
    end
  end

  // Status outputs registered from the next state so they track state_r exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r <= 1'b1;
      cpu_rst_r  <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      in_ready_r <= (state_s == ST_HDR0) || (state_s == ST_HDR1) ||
                    (state_s == ST_DATA) || (state_s == ST_CSUM);
      cpu_rst_r  <= (state_s != ST_DONE);
      done_r     <= (state_s == ST_DONE);
      error_r    <= (state_s == ST_ERR);
    end
  end

  // Header capture, checksum, word assembly and RAM write generation.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= 16'd0;
      csum_r     <= 8'd0;
      byte_idx_r <= 2'd0;
      word_idx_r <= 16'd0;
      buf_r      <= 24'd0;
      we_r       <= 1'b0;
      waddr_r    <= BASE_ADDR;
      wdata_r    <= 32'd0;
    end else begin
      we_r <= 1'b0;
      if (accept_s) begin
        case (state_r)
          ST_HDR0: begin
            cnt_r[7:0] <= in_data;
            csum_r     <= csum_add(csum_r, in_data);
          end
          ST_HDR1: begin
            cnt_r[15:8] <= in_data;
            csum_r      <= csum_add(csum_r, in_data);
          end
          ST_DATA: begin
            csum_r     <= csum_add(csum_r, in_data);
            byte_idx_r <= byte_idx_r + 2'd1;
            case (byte_idx_r)
              2'd0: buf_r[7:0]   <= in_data;
              2'd1: buf_r[15:8]  <= in_data;
              2'd2: buf_r[23:16] <= in_data;
              2'd3: begin
                // b3 completes the word; address uses the pre-increment index.
                we_r       <= 1'b1;
                wdata_r    <= {in_data, buf_r};
                waddr_r    <= BASE_ADDR + {14'd0, word_idx_r, 2'b00};
                word_idx_r <= word_idx_r + 16'd1;
              end
              default: buf_r <= buf_r;
            endcase
          end
          // CSUM byte is compared, not accumulated; terminal states never accept.
          default: csum_r <= csum_r;
        endcase
      end
    end
  end

  assign in_ready     = in_ready_r;
  assign we           = we_r;
  assign waddr        = waddr_r;
  assign wdata        = wdata_r;
  assign cpu_rst      = cpu_rst_r;
  assign done         = done_r;
  assign error        = error_r;
  // Word index advances on the same edge that raises we.
  assign words_loaded = word_idx_r;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: stream-position reference model checked every cycle,
// directed stream scenarios with literal expectations, then randomized streams.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam int MAXW = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  imem_loader #(.BASE_ADDR(32'h0040_0000), .MAX_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error), .words_loaded(words_loaded)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: interprets the stream by byte position.
  int          m_pos;
  int          m_n;
  logic [7:0]  m_sum;
  int          m_status;   // 0 loading, 1 done, 2 error
  logic [31:0] m_word;
  bit          m_live = 1'b0;
  bit          m_fresh;
  logic        e_we;
  logic [31:0] e_waddr;
  logic [31:0] e_wdata;
  logic [15:0] e_words;

  logic [63:0] wr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit r);
    int k;
    e_we = 1'b0;
    if (r) begin
      m_pos = 0; m_n = 0; m_sum = 8'd0; m_status = 0; m_word = 32'd0;
      e_waddr = BASE; e_wdata = 32'd0; e_words = 16'd0;
      m_fresh = 1'b1; m_live = 1'b1;
    end else if (v && m_status == 0) begin
      if (m_pos == 0) begin
        m_n = int'(d);
        m_sum = m_sum + d;
      end else if (m_pos == 1) begin
        m_n = m_n + 256 * int'(d);
        m_sum = m_sum + d;
        if (m_n == 0 || m_n > MAXW) m_status = 2;
      end else if (m_pos < 2 + 4 * m_n) begin
        k = m_pos - 2;
        m_sum = m_sum + d;
        m_word[8*(k%4) +: 8] = d;
        if (k % 4 == 3) begin
          e_we = 1'b1;
          e_waddr = BASE + 32'(4 * (k / 4));
          e_wdata = m_word;
          e_words = 16'(k / 4 + 1);
          m_fresh = 1'b0;
        end
      end else begin
        m_status = (d == m_sum) ? 1 : 2;
      end
      m_pos++;
    end
  endtask

  // Compare process: DUT outputs against the model every cycle, mid-period.
  always @(negedge clk) begin
    if (m_live) begin
      check("we", 32'(we), 32'(e_we));
      if (e_we || m_fresh) begin
        check("waddr", waddr, e_waddr);
        check("wdata", wdata, e_wdata);
      end
      check("in_ready", 32'(in_ready), 32'(m_status == 0));
      check("done", 32'(done), 32'(m_status == 1));
      check("error", 32'(error), 32'(m_status == 2));
      check("cpu_rst", 32'(cpu_rst), 32'(m_status != 1));
      check("words_loaded", 32'(words_loaded), 32'(e_words));
      if (we === 1'b1) wr_q.push_back({waddr, wdata});
    end
  end

  task automatic step(input bit v, input logic [7:0] d, input bit r);
    @(negedge clk);
    in_valid = v; in_data = d; rst = r;
    @(posedge clk);
    model_step(v, d, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 8'd0, 1'b1);
    step(1'b0, 8'd0, 1'b1);
    wr_q.delete();
  endtask

  // Send bytes back-to-back, or with `gap` idle cycles (random data) before each.
  task automatic send(input logic [7:0] b[$], input int gap);
    foreach (b[i]) begin
      idle(gap);
      step(1'b1, b[i], 1'b0);
    end
  endtask

  task automatic check_nominal(input string tag);
    check({tag, "_nwr"}, 32'(wr_q.size()), 32'd2);
    if (wr_q.size() >= 2) begin
      check({tag, "_a0"}, wr_q[0][63:32], 32'h0040_0000);
      check({tag, "_d0"}, wr_q[0][31:0], 32'h0060_0413);
      check({tag, "_a1"}, wr_q[1][63:32], 32'h0040_0004);
      check({tag, "_d1"}, wr_q[1][31:0], 32'h0040_0493);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd2);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    logic [7:0] nom[$];
    logic [7:0] bad[$];
    logic [7:0] q[$];
    logic [7:0] sum;
    int n;
    int idx;

    nom = '{8'h02, 8'h00, 8'h13, 8'h04, 8'h60, 8'h00, 8'h93, 8'h04, 8'h40, 8'h00, 8'h50};
    bad = nom;
    bad[10] = 8'h51;

    // Reset state.
    do_reset();
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_waddr", waddr, 32'h0040_0000);
    check("rst_wdata", wdata, 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_done_err", 32'({done, error, we}), 32'd0);

    // Nominal load.
    send(nom, 0);
    idle(3);
    #1;
    check_nominal("nom");

    // Bad checksum, then extra bytes that must be ignored.
    do_reset();
    send(bad, 0);
    send('{8'h11, 8'h22, 8'h33}, 0);
    idle(2);
    #1;
    check("badcs_nwr", 32'(wr_q.size()), 32'd2);
    check("badcs_error", 32'(error), 32'd1);
    check("badcs_done", 32'(done), 32'd0);
    check("badcs_cpu_rst", 32'(cpu_rst), 32'd1);
    check("badcs_in_ready", 32'(in_ready), 32'd0);
    check("badcs_words", 32'(words_loaded), 32'd2);

    // Zero count: error the cycle after CNT_HI.
    do_reset();
    send('{8'h00, 8'h00}, 0);
    #1;
    check("zero_error", 32'(error), 32'd1);
    check("zero_in_ready", 32'(in_ready), 32'd0);
    idle(6);
    #1;
    check("zero_nwr", 32'(wr_q.size()), 32'd0);
    check("zero_cpu_rst", 32'(cpu_rst), 32'd1);

    // Oversize count 1025.
    do_reset();
    send('{8'h01, 8'h04}, 0);
    #1;
    check("over_error", 32'(error), 32'd1);
    idle(6);
    check("over_nwr", 32'(wr_q.size()), 32'd0);

    // Count 1024 is the largest accepted.
    do_reset();
    send('{8'h00, 8'h04}, 0);
    #1;
    check("max_in_ready", 32'(in_ready), 32'd1);
    check("max_error", 32'(error), 32'd0);

    // Gapped input: valid every third cycle.
    do_reset();
    send(nom, 2);
    idle(3);
    #1;
    check_nominal("gap");

    // Reset mid-word, then the full nominal stream.
    do_reset();
    send('{8'h02, 8'h00, 8'h13, 8'h04, 8'h60}, 0);
    idle(2);
    check("mid_pre_nwr", 32'(wr_q.size()), 32'd0);
    step(1'b1, 8'h00, 1'b1);
    send(nom, 0);
    idle(3);
    #1;
    check_nominal("mid");

    // Randomized programs with random gaps, occasional bad header/checksum/reset.
    for (int t = 0; t < 40; t++) begin
      do_reset();
      q.delete();
      n = $urandom_range(1, 6);
      if ($urandom_range(0, 9) == 0) n = 0;
      if ($urandom_range(0, 9) == 0) n = 1025 + $urandom_range(0, 100);
      q.push_back(8'(n));
      q.push_back(8'(n >> 8));
      if (n <= MAXW) begin
        for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
      end
      sum = 8'd0;
      foreach (q[i]) sum = sum + q[i];
      if ($urandom_range(0, 4) == 0) sum = sum ^ 8'(1 << $urandom_range(0, 7));
      q.push_back(sum);
      q.push_back(8'($urandom));
      idx = 0;
      while (idx < q.size()) begin
        if ($urandom_range(0, 199) == 0) begin
          step(1'b1, 8'($urandom), 1'b1);
        end else if ($urandom_range(0, 9) < 6) begin
          step(1'b1, q[idx], 1'b0);
          idx++;
        end else begin
          step(1'b0, 8'($urandom), 1'b0);
        end
      end
      idle(3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
